// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 16;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction so the following left shift carries correctly into the next digit.
  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-add-3).
// Optional feature macro: SEG_BCD_SIGNED_EN (two's complement input, sign on neg_o).
module bin_to_bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             neg_o
);

  localparam int unsigned CntW = 4;

  if (WIDTH < 2 || WIDTH > 13) begin : g_width_check
    $error("bin_to_bcd_seq: WIDTH must be in 2..13");
  end

  bcd_state_e       state_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mag;
  logic             accept, finish;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*i +: 4]),
      .digit_o (adj[4*i +: 4])
    );
  end

  // Operand magnitude loaded into the shift register on acceptance.
  always_comb begin
`ifdef SEG_BCD_SIGNED_EN
    mag = value_i[WIDTH-1] ? (~value_i + WIDTH'(1)) : value_i;
`else
    mag = value_i;
`endif
  end

  // One double-dabble step: adjusted digits and operand shift left as one word.
  always_comb begin
    shifted   = {adj, shreg_q} << 1;
    scratch_d = shifted[BCD_W+WIDTH-1:WIDTH];
    shreg_d   = shifted[WIDTH-1:0];
    accept    = (state_q == StIdle) && start_i;
    finish    = (state_q == StShift) && (cnt_q == CntW'(1));
  end

  // Control FSM with registered busy/done/bcd.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StShift;
            shreg_q   <= mag;
            scratch_q <= '0;
            cnt_q     <= CntW'(WIDTH);
            busy_q    <= 1'b1;
          end
        end
        StShift: begin
          shreg_q   <= shreg_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CntW'(1);
          if (finish) begin
            // Result is published on entry to StDone so it is valid alongside done.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scratch_d;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEG_BCD_SIGNED_EN
  logic sign_q, neg_q;

  // Sign is captured at acceptance but only shown once the matching digits are.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (accept) sign_q <= value_i[WIDTH-1];
      if (finish) neg_q  <= sign_q;
    end
  end

  assign neg_o = neg_q;
`else
  assign neg_o = 1'b0;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8 and WIDTH=13 instances).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start13;
  logic [7:0]  val8;
  logic [12:0] val13;
  logic        busy8, done8, neg8, busy13, done13, neg13;
  logic [15:0] bcd8, bcd13;

  int checks = 0;
  int errors = 0;

  logic [15:0] prev_bcd;
  logic        prev_neg;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start8),
    .value_i (val8),
    .busy_o  (busy8),
    .done_o  (done8),
    .bcd_o   (bcd8),
    .neg_o   (neg8)
  );

  bin_to_bcd_seq #(.WIDTH(13)) dut13 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start13),
    .value_i (val13),
    .busy_o  (busy13),
    .done_o  (done13),
    .bcd_o   (bcd13),
    .neg_o   (neg13)
  );

  typedef struct {
    logic [7:0]  val;
    logic [15:0] bcd;
    logic        neg;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: decimal digits of the (possibly signed) value by plain arithmetic.
  function automatic logic [16:0] model(input int w, input int unsigned v);
    int unsigned mag;
    logic        n;
    mag = v;
    n   = 1'b0;
`ifdef SEG_BCD_SIGNED_EN
    if (((v >> (w - 1)) & 1) == 1) begin
      n   = 1'b1;
      mag = (32'd1 << w) - v;
    end
`endif
    return {n, 4'(mag / 1000 % 10), 4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
  endfunction

  // Full conversion on the 8-bit DUT, checked cycle by cycle.
  task automatic run8(input logic [7:0] v, input logic [15:0] eb, input logic en,
                      input string name);
    val8   = v;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    val8   = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      check({name, " busy"}, busy8, 1'b1);
      check({name, " early done"}, done8, 1'b0);
      check({name, " bcd hold"}, bcd8, prev_bcd);
      check({name, " neg hold"}, neg8, prev_neg);
      tick();
    end
    check({name, " done"}, done8, 1'b1);
    check({name, " busy at done"}, busy8, 1'b0);
    check({name, " bcd"}, bcd8, eb);
    check({name, " neg"}, neg8, en);
    prev_bcd = eb;
    prev_neg = en;
    tick();
    check({name, " done pulse width"}, done8, 1'b0);
    check({name, " bcd after done"}, bcd8, eb);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [16:0] m;
    int          dones;
    int          last;

    rst = 1'b1; start8 = 1'b0; start13 = 1'b0; val8 = '0; val13 = '0;
    prev_bcd = '0; prev_neg = 1'b0;

`ifdef SEG_BCD_SIGNED_EN
    vecs[0] = '{8'hF9, 16'h0007, 1'b1};
    vecs[1] = '{8'h80, 16'h0128, 1'b1};
    vecs[2] = '{8'h7F, 16'h0127, 1'b0};
    vecs[3] = '{8'h00, 16'h0000, 1'b0};
    vecs[4] = '{8'h09, 16'h0009, 1'b0};
    vecs[5] = '{8'hFF, 16'h0001, 1'b1};
`else
    vecs[0] = '{8'd255, 16'h0255, 1'b0};
    vecs[1] = '{8'd0,   16'h0000, 1'b0};
    vecs[2] = '{8'd9,   16'h0009, 1'b0};
    vecs[3] = '{8'd100, 16'h0100, 1'b0};
    vecs[4] = '{8'd99,  16'h0099, 1'b0};
    vecs[5] = '{8'd200, 16'h0200, 1'b0};
`endif

    // Reset state, with start asserted to show reset wins.
    start8 = 1'b1;
    tick();
    tick();
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset bcd", bcd8, 16'h0000);
    check("reset neg", neg8, 1'b0);
    check("reset busy13", busy13, 1'b0);
    check("reset bcd13", bcd13, 16'h0000);
    start8 = 1'b0;
    rst    = 1'b0;
    tick();
    check("idle after reset", busy8, 1'b0);

    foreach (vecs[i]) run8(vecs[i].val, vecs[i].bcd, vecs[i].neg, $sformatf("vec%0d", i));

    // Start during SHIFT is ignored and not queued.
    m      = model(8, 255);
    val8   = 8'd255;
    start8 = 1'b1;
    tick();
    dones  = 0;
    for (int c = 1; c <= 12; c++) begin
      start8 = (c == 4);
      val8   = (c == 4) ? 8'd17 : 8'd255;
      if (c == 9) begin
        check("ignore done", done8, 1'b1);
        check("ignore bcd", bcd8, m[15:0]);
        check("ignore neg", neg8, m[16]);
      end
      if (done8) dones++;
      tick();
    end
    start8 = 1'b0;
    check("ignore done count", dones, 1);
    prev_bcd = m[15:0];
    prev_neg = m[16];

    // Reset mid-conversion aborts without a done.
    val8   = 8'd123;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy8, 1'b0);
    check("abort done", done8, 1'b0);
    check("abort bcd", bcd8, 16'h0000);
    check("abort neg", neg8, 1'b0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) dones++;
      tick();
    end
    check("abort no done", dones, 0);
    check("abort idle busy", busy8, 1'b0);
    prev_bcd = '0;
    prev_neg = 1'b0;

    // Randomized values against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      int unsigned v;
      v = $urandom_range(0, 255);
      m = model(8, v);
      run8(8'(v), m[15:0], m[16], $sformatf("rand%0d", i));
    end

    // Held start on the 13-bit instance: back-to-back conversions every WIDTH+2 cycles.
    m       = model(13, 8191);
    val13   = 13'd8191;
    start13 = 1'b1;
    last    = -1;
    dones   = 0;
    for (int c = 0; c < 64; c++) begin
      if (busy13 && done13) check("busy and done overlap", 1'b1, 1'b0);
      if (done13) begin
        dones++;
        check("held bcd", bcd13, m[15:0]);
        check("held neg", neg13, m[16]);
        if (last < 0) check("held first done cycle", c, 14);
        else check("held done interval", c - last, 15);
        last = c;
      end
      tick();
    end
    start13 = 1'b0;
    check("held done count", dones, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter between the math block and the seven-segment decoder. It accepts a result word on a start pulse and runs the shift-add-3 (double-dabble) algorithm, one bit per clock. It then presents four packed BCD digits, which the decoder indexes by the active anode. Results therefore display in decimal instead of hex.

## Interface
- WIDTH, 8, input word width in bits; legal range 2..13, so the result always fits in 4 digits (max 8191).
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; tied to the board reset button at top level.
- start  input  1  request; sampled only in IDLE.
- value  input  WIDTH  binary operand; captured on an accepted start.
- busy  output  1  high from the cycle after acceptance until done is asserted.
- done  output  1  one-cycle pulse; bcd and neg are valid and updated in this same cycle.
- bcd  output  16  packed digits: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- neg  output  1  sign of the last converted value (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE -> SHIFT when start=1. On that edge, value (or its magnitude) loads into the shift register, the scratch BCD register clears, and the bit counter loads WIDTH.
  - SHIFT lasts exactly WIDTH cycles. Each cycle:
    - every scratch digit >= 5 gets +3;
    - then {scratch, shreg} shifts left by 1;
    - the counter decrements.
  - Exit to DONE when the counter reaches 1 and that cycle's shift completes.
  - DONE lasts one cycle and copies scratch to bcd. Next state is always IDLE.
- bcd and neg hold their values between completions. They change only on entry to DONE or on reset.
- start in SHIFT or DONE is ignored and not queued.
- A steady start=1 re-triggers a new conversion on each return to IDLE.
- Reset values: FSM=IDLE, busy=0, done=0, bcd=16'h0000, neg=0, internal registers zero.
- Reset mid-conversion aborts the conversion. The outputs go to their reset values and no done is emitted.
- If reset and start arrive in the same cycle, reset wins.

## Timing
- Start accepted at edge N. busy=1 for cycles N+1..N+WIDTH. done=1 and the new bcd are visible at cycle N+WIDTH+1. The FSM is back in IDLE at N+WIDTH+2.
- Latency from start to done is WIDTH+1 cycles. Throughput is one conversion per WIDTH+2 cycles.
- busy and done are never high together.
- Digit adjust is combinational within a single cycle. There is no multi-cycle path.

## Configuration
- SEG_BCD_SIGNED_EN defined:
  - value is two's complement;
  - on acceptance, neg latches value[WIDTH-1] and the magnitude (-value when negative) is converted;
  - -2^(WIDTH-1) converts correctly because its magnitude fits in WIDTH bits unsigned;
  - neg updates together with bcd at done.
- SEG_BCD_SIGNED_EN undefined:
  - value is unsigned and neg is constant 0;
  - no negation logic is built.

## Structure
- Shared package seg_pkg holds:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - BCD_DIGITS = 4;
  - BCD_W = 16.
- Sub-module bcd_digit_adj: 4-bit combinational "add 3 if >= 5". Instantiate it BCD_DIGITS times.
- Elaboration-time check rejects WIDTH outside 2..13.

## Test plan
- WIDTH=8, unsigned, value=8'd255, start pulse at cycle 0 -> busy cycles 1..8; done at cycle 9 with bcd=16'h0255, neg=0.
- value=8'd0 -> done at cycle 9, bcd=16'h0000. Then value=8'd9 -> bcd=16'h0009 (checks the no-adjust path and the hold between runs).
- start pulsed again at cycle 4 with value=8'd17 during a 255 conversion -> ignored; done at 9 with 16'h0255; only one done pulse.
- reset asserted at cycle 5 of a conversion -> the next cycle shows busy=0, bcd=0, and no done in the following 12 cycles.
- SEG_BCD_SIGNED_EN defined, WIDTH=8:
  - 8'hF9 -> bcd=16'h0007, neg=1;
  - 8'h80 -> bcd=16'h0128, neg=1;
  - 8'h7F -> bcd=16'h0127, neg=0.
- start held high continuously, WIDTH=13, value=13'd8191 -> done every 15 cycles, each with bcd=16'h8191.
